fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, 2-entry in-order
// response FIFO, redirect with flush and stale-response drop.
module fetch_stage #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);

    localparam logic [DWIDTH-1:0] NOP        = DWIDTH'(32'h0000_0013);
    localparam logic [AWIDTH-1:0] ALIGN_MASK = ~AWIDTH'(3);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] fpc_q, fpc_d;
    logic [AWIDTH-1:0] req_pc_q, req_pc_d;
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;

    logic [AWIDTH-1:0] fifo_pc_q   [2];
    logic [DWIDTH-1:0] fifo_insn_q [2];

    logic              fifo_empty;
    logic              accept;
    logic              rsp_seen;
    logic              push;
    logic              pop;
    logic              tail;
    logic [AWIDTH-1:0] redirect_fpc;

    assign fifo_empty   = (count_q == 2'd0);
    assign tail         = head_q ^ count_q[0];
    assign redirect_fpc = redirect_pc_i & ALIGN_MASK;

    // Only REQ can have nothing outstanding, so count < 2 is the whole credit check.
    assign imem_req_valid_o = !rst && (state_q == S_REQ) && (count_q != 2'd2);
    assign imem_req_addr_o  = fpc_q & ALIGN_MASK;

    assign valid_o = !rst && !fifo_empty;
    assign pc_o    = rst ? RESET_PC : (fifo_empty ? fpc_q : fifo_pc_q[head_q]);
    assign insn_o  = valid_o ? fifo_insn_q[head_q] : NOP;

    assign accept   = imem_req_valid_o && imem_req_ready_i;
    assign rsp_seen = (state_q != S_REQ) && imem_rsp_valid_i;
    assign push     = (state_q == S_WAIT) && imem_rsp_valid_i && !redirect_i;
    assign pop      = valid_o && !stall_i && !redirect_i;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        head_d   = head_q;
        count_d  = count_q;

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d  = S_WAIT;
                    fpc_d    = fpc_q + AWIDTH'(4);
                    req_pc_d = fpc_q & ALIGN_MASK;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_i) begin
            fpc_d   = redirect_fpc;
            head_d  = 1'b0;
            count_d = 2'd0;
            // A redirect that coincides with the last outstanding response
            // leaves nothing in flight, so fetch restarts immediately.
            if (state_q == S_REQ) begin
                state_d = accept ? S_DROP : S_REQ;
            end else begin
                state_d = rsp_seen ? S_REQ : S_DROP;
            end
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            fpc_q    <= RESET_PC;
            req_pc_q <= RESET_PC;
            head_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_pc_q <= req_pc_d;
            head_q   <= head_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail]   <= req_pc_q;
            fifo_insn_q[tail] <= imem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-vector table followed by multi-cycle
// sequences driven by a 1-cycle-latency instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] R   = 32'h0100_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] insn_o;

    int          checks;
    int          errors;
    logic        auto_rsp;
    logic [31:0] exp_pc;

    fetch_stage #(
        .DWIDTH  (32),
        .AWIDTH  (32),
        .RESET_PC(32'h0100_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .valid_o         (valid_o),
        .pc_o            (pc_o),
        .insn_o          (insn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        redir;
        logic [31:0] redir_pc;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_insn;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Samples request handshake mid-cycle; when auto_rsp is set the memory
    // answers every accepted request in the following cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid_o && imem_req_ready_i;
        a   = imem_req_addr_o;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid_i = acc;
            imem_rsp_data_i  = acc ? memword(a) : 32'h0;
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid_o) break;
            tick();
        end
        chk("wait_req_timeout", 32'(imem_req_valid_o), 32'd1);
    endtask

    task automatic collect(input int n, input int budget);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (valid_o && !stall_i) begin
                chk("stream_pc", pc_o, exp_pc);
                chk("stream_insn", insn_o, memword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            tick();
        end
        chk("stream_count", 32'(got), 32'(n));
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        auto_rsp         = 1'b0;
        rst              = 1'b1;
        stall_i          = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;

        //          rst stall rdy rspv rsp_d         redir redir_pc       e_rv e_addr          e_v e_pc            e_insn
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, R,              1'b0, R,              NOP};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R,              1'b0, R,              NOP};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0000,  1'b0, 32'h0,          1'b0, R + 32'h4,      1'b0, R + 32'h4,      NOP};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R + 32'h4,      1'b1, R,              32'hA000_0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0001,  1'b0, 32'h0,          1'b0, R + 32'h8,      1'b0, R + 32'h8,      NOP};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R + 32'h8,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, BAD,            1'b0, 32'h0,          1'b1, R + 32'h8,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R + 32'h8,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA000_0002,  1'b0, 32'h0,          1'b0, R + 32'hC,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, R + 32'hC,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, R + 32'hC,      1'b1, R + 32'h4,      32'hA000_0001};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R + 32'hC,      1'b1, R + 32'h8,      32'hA000_0002};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0200_0007,  1'b1, R + 32'hC,      1'b1, R + 32'h8,      32'hA000_0002};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h0200_0004,  1'b0, 32'h0200_0004,  NOP};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0200_0004,  1'b0, R,              NOP};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, R,              1'b0, R,              NOP};

        tick();
        tick();

        for (int i = 0; i < 16; i++) begin
            rst              = tbl[i].rst;
            stall_i          = tbl[i].stall;
            imem_req_ready_i = tbl[i].ready;
            imem_rsp_valid_i = tbl[i].rsp_v;
            imem_rsp_data_i  = tbl[i].rsp_d;
            redirect_i       = tbl[i].redir;
            redirect_pc_i    = tbl[i].redir_pc;
            #1;
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid_o), 32'(tbl[i].e_req_v));
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("vec%0d_insn", i), insn_o, tbl[i].e_insn);
            tick();
        end

        // Streaming from reset
        stall_i          = 1'b0;
        redirect_i       = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
        auto_rsp         = 1'b1;
        rst              = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_reset_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("post_reset_req_addr", imem_req_addr_o, R);
        exp_pc = R;
        collect(3, 40);

        // Stall for 5 cycles: FIFO fills, requests stop, head held
        stall_i = 1'b1;
        repeat (5) tick();
        chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_pc_held", pc_o, exp_pc);
        chk("stall_insn_held", insn_o, memword(exp_pc));
        stall_i = 1'b0;
        #1;
        collect(4, 40);

        // Redirect in WAIT with no response: DROP then refetch aligned target
        wait_req();
        auto_rsp         = 1'b0;
        imem_rsp_valid_i = 1'b0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0100_0043;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("drop_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("drop_valid", 32'(valid_o), 32'd0);
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = BAD;
        tick();
        imem_rsp_valid_i = 1'b0;
        #1;
        chk("drop_done_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("drop_done_req_addr", imem_req_addr_o, 32'h0100_0040);
        chk("drop_done_valid", 32'(valid_o), 32'd0);
        auto_rsp = 1'b1;
        tick();
        chk("redir_wait_valid", 32'(valid_o), 32'd0);
        tick();
        chk("redir_first_valid", 32'(valid_o), 32'd1);
        chk("redir_first_pc", pc_o, 32'h0100_0040);
        chk("redir_first_insn", insn_o, memword(32'h0100_0040));

        // Redirect coinciding with a response: no DROP cycle
        wait_req();
        auto_rsp         = 1'b0;
        imem_rsp_valid_i = 1'b0;
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = BAD;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h0000_2000;
        tick();
        imem_rsp_valid_i = 1'b0;
        redirect_i       = 1'b0;
        #1;
        chk("coinc_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("coinc_req_addr", imem_req_addr_o, 32'h0000_2000);
        chk("coinc_valid", 32'(valid_o), 32'd0);
        auto_rsp = 1'b1;
        tick();
        tick();
        chk("coinc_first_valid", 32'(valid_o), 32'd1);
        chk("coinc_first_pc", pc_o, 32'h0000_2000);
        chk("coinc_first_insn", insn_o, memword(32'h0000_2000));

        // Ready held low: address stable; then wrap at top of address space
        auto_rsp         = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("notready%0d_req_valid", i), 32'(imem_req_valid_o), 32'd1);
            chk($sformatf("notready%0d_addr", i), imem_req_addr_o, 32'hFFFF_FFFC);
            tick();
        end
        auto_rsp         = 1'b1;
        imem_req_ready_i = 1'b1;
        tick();
        chk("wrap_next_addr", imem_req_addr_o, 32'h0000_0000);
        tick();
        chk("wrap_valid", 32'(valid_o), 32'd1);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_insn", insn_o, memword(32'hFFFF_FFFC));
        chk("wrap_req_addr", imem_req_addr_o, 32'h0000_0000);

        // Reset during WAIT with a stale response arriving afterwards
        wait_req();
        auto_rsp         = 1'b0;
        imem_rsp_valid_i = 1'b0;
        tick();
        rst              = 1'b1;
        imem_req_ready_i = 1'b0;
        tick();
        rst              = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = BAD;
        #1;
        chk("rstwait_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("rstwait_req_addr", imem_req_addr_o, R);
        chk("rstwait_pc", pc_o, R);
        tick();
        imem_rsp_valid_i = 1'b0;
        #1;
        chk("stale_ignored_valid", 32'(valid_o), 32'd0);
        auto_rsp         = 1'b1;
        imem_req_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) break;
            tick();
        end
        chk("rstwait_first_valid", 32'(valid_o), 32'd1);
        chk("rstwait_first_pc", pc_o, R);
        chk("rstwait_first_insn", insn_o, memword(R));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
